// File: rtl/eeprom_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : eeprom_burst_seq
// Brief    : Multi-byte EEPROM write/read burst sequencer for an I2C byte
//            controller. Define EEPROM_VERIFY_EN to build read-back checking.
// Revision : 1.0 - initial release
// ============================================================================
module eeprom_burst_seq #(
    parameter int          BURST_LEN   = 16,
    parameter int          ADDR_W      = 16,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter logic [7:0]  DATA_INIT   = 8'h01,
    parameter int          TWR_CYC     = 250_000,
    parameter int          TIMEOUT_CYC = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write,
    input  logic        read,
    input  logic        i2c_end,
    input  logic [7:0]  rd_data,
    output logic        wr_en,
    output logic        rd_en,
    output logic        i2c_start,
    output logic [15:0] byte_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        rd_valid,
    output logic [7:0]  rd_byte,
    output logic [7:0]  rd_idx,
    output logic        done,
    output logic        err
`ifdef EEPROM_VERIFY_EN
    ,
    output logic [8:0]  vfy_err_cnt,
    output logic        vfy_ok
`endif
);

    localparam int c_TWR_W = (TWR_CYC > 1) ? $clog2(TWR_CYC + 1) : 1;
    localparam int c_TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [c_TWR_W-1:0] c_TWR_LAST  = c_TWR_W'(TWR_CYC);
    localparam logic [c_TO_W-1:0]  c_TO_LAST   = c_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]         c_LAST_IDX  = 8'(BURST_LEN - 1);
    localparam logic [15:0]        c_ADDR_MASK = (ADDR_W >= 16) ? 16'hFFFF
                                                 : 16'((32'd1 << ADDR_W) - 32'd1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_WR_START = 3'd1;
    localparam logic [2:0] c_ST_WR_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_WR_TWR   = 3'd3;
    localparam logic [2:0] c_ST_RD_START = 3'd4;
    localparam logic [2:0] c_ST_RD_WAIT  = 3'd5;
    localparam logic [2:0] c_ST_FINISH   = 3'd6;

    logic [2:0]         r_state;
    logic [7:0]         r_idx;
    logic [c_TWR_W-1:0] r_twr;
    logic [c_TO_W-1:0]  r_wdog;
    logic               r_end_d;
    logic               r_rd_pend;   // read byte captured, advance decision next cycle

    logic               w_end_rise;
    logic               w_last;
    logic               w_twr_done;
    logic               w_timeout;
    logic [7:0]         w_next_idx;

    assign w_end_rise = i2c_end & ~r_end_d;
    assign w_last     = (r_idx == c_LAST_IDX);
    assign w_twr_done = (r_twr == c_TWR_LAST);
    assign w_timeout  = (r_wdog == c_TO_LAST);
    assign w_next_idx = r_idx + 8'd1;

    function automatic logic [15:0] f_addr(input logic [7:0] k);
        logic [15:0] s;
        s = BASE_ADDR + {8'h00, k};
        return s & c_ADDR_MASK;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_idx     <= 8'd0;
            r_twr     <= '0;
            r_wdog    <= '0;
            r_end_d   <= 1'b0;
            r_rd_pend <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            i2c_start <= 1'b0;
            byte_addr <= 16'd0;
            wr_data   <= 8'd0;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_byte   <= 8'd0;
            rd_idx    <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_end_d   <= i2c_end;
            i2c_start <= 1'b0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (write) begin
                        r_idx     <= 8'd0;
                        byte_addr <= f_addr(8'd0);
                        wr_data   <= DATA_INIT;
                        wr_en     <= 1'b1;
                        i2c_start <= 1'b1;
                        busy      <= 1'b1;
                        r_wdog    <= '0;
                        r_state   <= c_ST_WR_START;
                    end else if (read) begin
                        r_idx     <= 8'd0;
                        byte_addr <= f_addr(8'd0);
                        rd_en     <= 1'b1;
                        i2c_start <= 1'b1;
                        busy      <= 1'b1;
                        r_wdog    <= '0;
                        r_state   <= c_ST_RD_START;
                    end
                end
                c_ST_WR_START: begin
                    r_wdog  <= r_wdog + 1'b1;
                    r_state <= c_ST_WR_WAIT;
                end
                c_ST_WR_WAIT: begin
                    if (w_end_rise) begin
                        wr_en   <= 1'b0;
                        r_twr   <= '0;
                        r_state <= c_ST_WR_TWR;
                    end else if (w_timeout) begin
                        wr_en   <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                c_ST_WR_TWR: begin
                    // TWR_CYC+1 cycles here puts the next start TWR_CYC+2 after the end edge
                    if (!w_twr_done) begin
                        r_twr <= r_twr + 1'b1;
                    end else if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= c_ST_FINISH;
                    end else begin
                        r_idx     <= w_next_idx;
                        byte_addr <= f_addr(w_next_idx);
                        wr_data   <= DATA_INIT + w_next_idx;
                        wr_en     <= 1'b1;
                        i2c_start <= 1'b1;
                        r_wdog    <= '0;
                        r_state   <= c_ST_WR_START;
                    end
                end
                c_ST_RD_START: begin
                    r_wdog  <= r_wdog + 1'b1;
                    r_state <= c_ST_RD_WAIT;
                end
                c_ST_RD_WAIT: begin
                    if (r_rd_pend) begin
                        r_rd_pend <= 1'b0;
                        if (w_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= c_ST_FINISH;
                        end else begin
                            r_idx     <= w_next_idx;
                            byte_addr <= f_addr(w_next_idx);
                            rd_en     <= 1'b1;
                            i2c_start <= 1'b1;
                            r_wdog    <= '0;
                            r_state   <= c_ST_RD_START;
                        end
                    end else if (w_end_rise) begin
                        rd_en     <= 1'b0;
                        rd_byte   <= rd_data;
                        rd_idx    <= r_idx;
                        rd_valid  <= 1'b1;
                        r_rd_pend <= 1'b1;
                    end else if (w_timeout) begin
                        rd_en   <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                c_ST_FINISH: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef EEPROM_VERIFY_EN
    logic w_rd_accept;
    logic w_capture;
    logic w_finish;

    assign w_rd_accept = (r_state == c_ST_IDLE) & read & ~write;
    assign w_capture   = (r_state == c_ST_RD_WAIT) & ~r_rd_pend & w_end_rise;
    assign w_finish    = w_last & (((r_state == c_ST_WR_TWR) & w_twr_done) |
                                   ((r_state == c_ST_RD_WAIT) & r_rd_pend));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vfy_err_cnt <= 9'd0;
            vfy_ok      <= 1'b0;
        end else begin
            if (w_rd_accept) begin
                vfy_err_cnt <= 9'd0;
            end else if (w_capture && (rd_data != (DATA_INIT + r_idx)) &&
                         (vfy_err_cnt != 9'd511)) begin
                vfy_err_cnt <= vfy_err_cnt + 9'd1;
            end
            if (w_finish) begin
                vfy_ok <= (vfy_err_cnt == 9'd0);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_eeprom_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_eeprom_burst_seq
// Brief    : Scoreboard bench for eeprom_burst_seq with a 20-cycle I2C model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eeprom_burst_seq;

    localparam int          c_LEN  = 4;
    localparam int          c_TWR  = 8;
    localparam int          c_TO   = 100;
    localparam logic [15:0] c_BASE = 16'hFFFE;
    localparam logic [7:0]  c_INIT = 8'hFE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        i2c_end = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        wr_en, rd_en, i2c_start, busy, rd_valid, done, err;
    logic [15:0] byte_addr;
    logic [7:0]  wr_data, rd_byte, rd_idx;
`ifdef EEPROM_VERIFY_EN
    logic [8:0]  vfy_err_cnt;
    logic        vfy_ok;
`endif

    eeprom_burst_seq #(
        .BURST_LEN  (c_LEN),
        .ADDR_W     (16),
        .BASE_ADDR  (c_BASE),
        .DATA_INIT  (c_INIT),
        .TWR_CYC    (c_TWR),
        .TIMEOUT_CYC(c_TO)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write      (write),
        .read       (read),
        .i2c_end    (i2c_end),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .i2c_start  (i2c_start),
        .byte_addr  (byte_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .rd_byte    (rd_byte),
        .rd_idx     (rd_idx),
        .done       (done),
        .err        (err)
`ifdef EEPROM_VERIFY_EN
        ,
        .vfy_err_cnt(vfy_err_cnt),
        .vfy_ok     (vfy_ok)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wr;
    } start_t;

    start_t      exp_start_q[$];
    logic [15:0] exp_rd_q[$];
    start_t      mon_e;
    logic [15:0] mon_r;

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          n_start = 0, n_rdv = 0, n_done = 0, n_err = 0;
    int          gap_ref = -1;
    int          t_start = 0;
    int          exp_gap = 30;
    int          exp_done_lat = 30;
    int          hold_cyc = 1;
    logic        no_resp = 1'b0;
    logic [7:0]  rd_tbl[4];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // I2C controller model: end edge 20 cycles after each start
    task automatic model_tx(input logic [15:0] a);
        logic [15:0] k;
        k = a - c_BASE;
        repeat (20) @(negedge clk);
        rd_data = rd_tbl[k[1:0]];
        i2c_end = 1'b1;
        repeat (hold_cyc) @(negedge clk);
        i2c_end = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && i2c_start && !no_resp) begin
            fork
                model_tx(byte_addr);
            join_none
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (i2c_start) begin
                n_start++;
                if (gap_ref >= 0) chk("start_gap", cyc - gap_ref, exp_gap);
                gap_ref = cyc;
                t_start = cyc;
                chk("start_expected", 32'(exp_start_q.size() != 0), 1);
                if (exp_start_q.size() != 0) begin
                    mon_e = exp_start_q.pop_front();
                    chk("start_addr", byte_addr, mon_e.addr);
                    chk("start_mode", {wr_en, rd_en}, mon_e.wr ? 2'b10 : 2'b01);
                    if (mon_e.wr) chk("start_data", wr_data, mon_e.data);
                end
            end
            if (rd_valid) begin
                n_rdv++;
                chk("rdv_lat", cyc - t_start, 21);
                chk("rdv_expected", 32'(exp_rd_q.size() != 0), 1);
                if (exp_rd_q.size() != 0) begin
                    mon_r = exp_rd_q.pop_front();
                    chk("rd_idx", rd_idx, mon_r[15:8]);
                    chk("rd_byte", rd_byte, mon_r[7:0]);
                end
            end
            if (done) begin
                n_done++;
                chk("done_lat", cyc - t_start, exp_done_lat);
                chk("done_busy", {busy, wr_en, rd_en}, 0);
            end
            if (err) begin
                n_err++;
                chk("err_lat", cyc - t_start, c_TO);
                chk("err_busy", {busy, wr_en, rd_en}, 0);
            end
        end
    end

    task automatic push_burst(input logic wr);
        start_t e;
        for (int k = 0; k < c_LEN; k++) begin
            e.addr = c_BASE + 16'(k);
            e.data = c_INIT + 8'(k);
            e.wr   = wr;
            exp_start_q.push_back(e);
            if (!wr) exp_rd_q.push_back({8'(k), rd_tbl[k]});
        end
        gap_ref      = -1;
        exp_gap      = wr ? (20 + c_TWR + 2) : 22;
        exp_done_lat = exp_gap;
    endtask

    task automatic request(input logic w, input logic r);
        @(posedge clk);
        #1;
        write = w;
        read  = r;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
        chk("req_busy", busy, 1);
        chk("req_start", i2c_start, 1);
    endtask

    task automatic wait_end(input int limit, output logic got_done, output logic got_err);
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            #1;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (err) begin
                got_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_burst_end(input string tag);
        logic gd, ge;
        wait_end(400, gd, ge);
        chk({tag, "_done"}, gd, 1);
        chk({tag, "_noerr"}, ge, 0);
        chk({tag, "_startq"}, exp_start_q.size(), 0);
        chk({tag, "_rdq"}, exp_rd_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {wr_en, rd_en, i2c_start, busy, rd_valid, done, err}, 0);
        chk({tag, "_addr"}, byte_addr, 0);
        chk({tag, "_data"}, {wr_data, rd_byte, rd_idx}, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

    initial begin
        int   base_s, base_r, base_d, base_e;
        logic gd, ge;

        rd_tbl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // write burst across the address wrap
        base_s = n_start;
        push_burst(1'b1);
        request(1'b1, 1'b0);
        check_burst_end("wr");
        chk("wr_starts", n_start - base_s, 4);

        // read burst, data mismatching the written pattern
        base_r = n_rdv;
        push_burst(1'b0);
        request(1'b0, 1'b1);
        check_burst_end("rd");
        chk("rd_count", n_rdv - base_r, 4);
`ifdef EEPROM_VERIFY_EN
        chk("vfy_cnt_bad", vfy_err_cnt, 4);
        chk("vfy_ok_bad", vfy_ok, 0);
`endif

        // matching data with i2c_end held high for 10 cycles
        rd_tbl   = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        hold_cyc = 10;
        base_r   = n_rdv;
        push_burst(1'b0);
        request(1'b0, 1'b1);
        check_burst_end("rd_hold");
        chk("rd_hold_count", n_rdv - base_r, 4);
`ifdef EEPROM_VERIFY_EN
        chk("vfy_cnt_good", vfy_err_cnt, 0);
        chk("vfy_ok_good", vfy_ok, 1);
`endif
        hold_cyc = 1;

        // simultaneous requests, then a read pulse mid-burst
        base_s = n_start;
        base_r = n_rdv;
        base_d = n_done;
        push_burst(1'b1);
        request(1'b1, 1'b1);
        for (int k = 0; k < 200 && n_start < base_s + 2; k++) @(negedge clk);
        @(posedge clk);
        #1;
        read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        check_burst_end("prio");
        chk("prio_starts", n_start - base_s, 4);
        chk("prio_no_rd", n_rdv - base_r, 0);
        repeat (30) @(negedge clk);
        chk("prio_one_done", n_done - base_d, 1);
        chk("prio_idle", busy, 0);

        // timeout with a silent controller
        no_resp = 1'b1;
        base_d  = n_done;
        base_e  = n_err;
        begin
            start_t e;
            e.addr = c_BASE;
            e.data = c_INIT;
            e.wr   = 1'b1;
            exp_start_q.push_back(e);
            gap_ref = -1;
        end
        request(1'b1, 1'b0);
        wait_end(300, gd, ge);
        chk("to_err", ge, 1);
        chk("to_nodone", gd, 0);
        repeat (10) @(negedge clk);
        chk("to_err_count", n_err - base_e, 1);
        chk("to_done_count", n_done - base_d, 0);
        chk("to_idle", {busy, wr_en, i2c_start}, 0);
        no_resp = 1'b0;

        // reset during the second write-cycle wait
        base_s = n_start;
        base_d = n_done;
        base_e = n_err;
        push_burst(1'b1);
        request(1'b1, 1'b0);
        for (int k = 0; k < 200 && n_start < base_s + 2; k++) @(negedge clk);
        chk("rst_reached_2nd", n_start - base_s, 2);
        repeat (25) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        exp_start_q.delete();
        exp_rd_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_done", n_done - base_d, 0);
        chk("abort_no_err", n_err - base_e, 0);

        // fresh burst restarts at the base address
        base_s = n_start;
        push_burst(1'b1);
        request(1'b1, 1'b0);
        check_burst_end("restart");
        chk("restart_starts", n_start - base_s, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eeprom_burst_seq.md
# eeprom_burst_seq

Parametrised EEPROM burst sequencer that replaces the fixed single-byte read/write driver between the debounced key flags and the I2C controller. It runs one multi-byte write burst or one multi-byte read burst per request. Each write is a byte-mode transaction followed by a programmable EEPROM write-cycle wait. Each read is a random-read transaction. Read bytes are streamed out with an index, so top-level display or UART logic can consume them directly.

## Interface
- BURST_LEN, 16: bytes per burst, 1..256
- ADDR_W, 16: EEPROM address width, 8 or 16; addresses wrap modulo 2^ADDR_W
- BASE_ADDR, 16'h0000: first byte address of every burst
- DATA_INIT, 8'h01: data written to byte 0; byte k gets (DATA_INIT + k) mod 256
- TWR_CYC, 250_000: clk cycles of internal write-cycle wait after each written byte (5 ms at 50 MHz)
- TIMEOUT_CYC, 2_000_000: clk cycles allowed per transaction before abort

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- write  in  1  one-cycle write-burst request (key flag)
- read  in  1  one-cycle read-burst request (key flag)
- i2c_end  in  1  controller transaction-complete; only its rising edge is used
- rd_data  in  8  controller read data, valid on the i2c_end rising edge
- wr_en  out  1  write transaction in progress
- rd_en  out  1  read transaction in progress
- i2c_start  out  1  one-cycle transaction start pulse
- byte_addr  out  16  current byte address; bits at and above ADDR_W are 0
- wr_data  out  8  current write byte
- busy  out  1  burst in progress
- rd_valid  out  1  one-cycle strobe: rd_byte/rd_idx valid
- rd_byte  out  8  captured read byte
- rd_idx  out  8  index k of rd_byte within the burst
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse on transaction timeout

## Operation
- States:
  - IDLE
  - WR_START, WR_WAIT, WR_TWR
  - RD_START, RD_WAIT
  - FINISH
- IDLE:
  - write → WR_START, and read → RD_START, each with idx=0.
  - If both are high in the same cycle, write wins and read is dropped.
  - Requests while busy=1 are ignored and are not queued.
- WR_START: i2c_start=1 for one cycle, wr_en=1, then → WR_WAIT.
- WR_WAIT:
  - wr_en held high.
  - On i2c_end rising edge → WR_TWR.
- WR_TWR:
  - Count TWR_CYC cycles.
  - Then, if idx==BURST_LEN-1 → FINISH; otherwise idx++ and → WR_START.
- RD_START / RD_WAIT: same as the write path but with rd_en. There is no TWR wait on reads.
- RD_WAIT on i2c_end rising edge:
  - Capture rd_data into rd_byte and idx into rd_idx; assert rd_valid on the next cycle.
  - Then → FINISH if idx was the last byte; otherwise idx++ and → RD_START.
- FINISH: done=1 for one cycle, then → IDLE.
- Addressing and data:
  - byte_addr = (BASE_ADDR + idx) mod 2^ADDR_W.
  - wr_data = DATA_INIT + idx, 8-bit wrap.
  - Both are stable from i2c_start through i2c_end.
- Timeout:
  - The watchdog counter clears at every i2c_start.
  - If TIMEOUT_CYC cycles elapse in WR_WAIT or RD_WAIT without i2c_end: pulse err, drop wr_en/rd_en, and → IDLE.
  - done is not pulsed on timeout.

## Timing
- Reset values: all outputs 0, state IDLE, idx 0. Reset mid-burst aborts immediately; no done or err is pulsed.
- Request latency: a request at cycle N gives busy=1 and i2c_start=1 at N+1.
- wr_en/rd_en rise with i2c_start and fall the cycle after the i2c_end edge is detected.
- Next start:
  - Read: i2c_start for the next byte is 2 cycles after the i2c_end edge is detected.
  - Write: i2c_start for the next byte is TWR_CYC+2 cycles after it.
- rd_valid rises exactly 1 cycle after the i2c_end edge is detected.
- done comes 1 cycle after the last rd_valid (read) or after the last TWR count (write). busy falls with done.
- i2c_end held high for many cycles counts once.

## Configuration
- EEPROM_VERIFY_EN defined:
  - Each captured read byte is compared with DATA_INIT + rd_idx.
  - Adds output vfy_err_cnt [8:0], which saturates at 511 and clears at each read request.
  - Adds output vfy_ok, updated on done: 1 when vfy_err_cnt==0, 0 otherwise.
- EEPROM_VERIFY_EN undefined: neither port exists and no compare logic is built.

## Test plan
All scenarios use BURST_LEN=4, TWR_CYC=8, TIMEOUT_CYC=100, BASE_ADDR=16'hFFFE, DATA_INIT=8'hFE, with a controller model that returns i2c_end 20 cycles after i2c_start.
- Write burst: write pulse → 4 i2c_start pulses at byte_addr FFFE, FFFF, 0000, 0001 and wr_data FE, FF, 00, 01. Starts are spaced 30 cycles apart; done occurs once.
- Read burst, model returns A0..A3 → rd_valid ×4 with rd_byte A0..A3 and rd_idx 0..3. Starts are 22 cycles apart. With verify built in, vfy_err_cnt=4 and vfy_ok=0; with model data FE, FF, 00, 01, vfy_ok=1.
- Priority and busy: write and read high in the same cycle → only the write burst runs. A read pulse during the burst → ignored.
- Timeout: the model never asserts i2c_end → err pulses 100 cycles after i2c_start, busy=0, no done.
- Reset: rst_n low during the second WR_TWR → all outputs 0 immediately. A fresh write afterwards starts again at FFFE.
- Held i2c_end: the model holds i2c_end high for 10 cycles → exactly one byte advance per transaction.
